// File: rtl/port_stream_bridge_pkg.sv
// Shared definitions for the CPU port stream bridge.
// Holds the bit positions of the CPU control word (portBOutput) and of the
// status word (portBInput), plus the common 32-bit word type.
package JZJCoreFTypes;

  typedef logic [31:0] word_t;

  // Control word fields driven by the CPU
  localparam int TX_TOGGLE_BIT    = 0;
  localparam int RX_TOGGLE_BIT    = 1;
  localparam int CLEAR_ERRORS_BIT = 2;

  // Status word fields read by the CPU
  localparam int TX_ACK_BIT       = 0;
  localparam int RX_ACK_BIT       = 1;
  localparam int TX_FULL_BIT      = 2;
  localparam int TX_EMPTY_BIT     = 3;
  localparam int RX_EMPTY_BIT     = 4;
  localparam int RX_FULL_BIT      = 5;
  localparam int TX_OVERFLOW_BIT  = 6;
  localparam int RX_UNDERFLOW_BIT = 7;
  localparam int TX_COUNT_LSB     = 8;
  localparam int RX_COUNT_LSB     = 16;
  localparam int COUNT_FIELD_W    = 8;

endpackage

// File: rtl/port_stream_bridge_if.sv
// Signal bundle between the bridge and its environment.
//   CPU side : cpuDataOut/cpuControlOut (CPU stores), cpuDataIn/cpuStatusIn
//              (CPU loads)
//   TX stream: txData/txValid toward the sink, txReady back from it
//   RX stream: rxData/rxValid from the source, rxReady back to it
// master = environment (CPU ports and stream endpoints), slave = bridge.
interface port_stream_bridge_if;
  import JZJCoreFTypes::*;

  word_t       cpuDataOut;
  logic [31:0] cpuControlOut;
  word_t       cpuDataIn;
  logic [31:0] cpuStatusIn;
  word_t       txData;
  logic        txValid;
  logic        txReady;
  word_t       rxData;
  logic        rxValid;
  logic        rxReady;

  modport master (
    output cpuDataOut, cpuControlOut, txReady, rxData, rxValid,
    input  cpuDataIn, cpuStatusIn, txData, txValid, rxReady
  );

  modport slave (
    input  cpuDataOut, cpuControlOut, txReady, rxData, rxValid,
    output cpuDataIn, cpuStatusIn, txData, txValid, rxReady
  );

endinterface

// File: rtl/port_stream_bridge_fifo.sv
// Show-ahead FIFO used for both bridge directions.
//   clock, reset (async, active-low)
//   push/pushData : write request; taken when not full, or when a pop is
//                   taken at the same edge
//   pop           : read request; taken only when not empty
//   head          : current oldest entry (meaningful only when !empty)
//   count/full/empty : occupancy, count is FIFO_DEPTH_LOG2+1 bits
// Storage is deliberately left out of reset; only pointers and count clear.
module port_stream_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int WIDTH           = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     full,
  output logic                     empty
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]           mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rdPtr;
  logic [FIFO_DEPTH_LOG2-1:0] wrPtr;
  logic                       popOk;
  logic                       pushOk;

  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);
  assign popOk  = pop && !empty;
  // A pop at the same edge frees a slot, so a full FIFO still accepts
  assign pushOk = push && (!full || popOk);
  assign head   = mem[rdPtr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/port_stream_bridge.sv
// Memory-mapped stream bridge behind the CPU's port A/B pair.
//   clock, reset (async, active-low)
//   bus.slave:
//     cpuDataOut    : TX word (portAOutput)
//     cpuControlOut : [0] txToggle, [1] rxToggle, [2] clearErrors (portBOutput)
//     cpuDataIn     : RX FIFO head, 0 when empty (portAInput)
//     cpuStatusIn   : acks, full/empty flags, sticky errors, counts (portBInput)
//     txData/txValid/txReady : outgoing stream
//     rxData/rxValid/rxReady : incoming stream
// Each change of a toggle bit is one command; the matching ack bit echoes
// the toggle so the CPU can poll for completion.
module port_stream_bridge
  import JZJCoreFTypes::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input logic                 clock,
  input logic                 reset,
  port_stream_bridge_if.slave bus
);

  logic [FIFO_DEPTH_LOG2:0] txCount;
  logic [FIFO_DEPTH_LOG2:0] rxCount;
  word_t                    txHead;
  word_t                    rxHead;
  logic txFull, txEmpty, rxFull, rxEmpty;
  logic txPrev, rxPrev, txAck, rxAck, txOverflow, rxUnderflow;
  logic txToggle, rxToggle, clearErrors;
  logic txCmd, rxCmd, txPop, rxPush, rxPop, newOverflow, newUnderflow;
  logic [31:0] status;
  logic unusedCtlBits;

  assign txToggle      = bus.cpuControlOut[TX_TOGGLE_BIT];
  assign rxToggle      = bus.cpuControlOut[RX_TOGGLE_BIT];
  assign clearErrors   = bus.cpuControlOut[CLEAR_ERRORS_BIT];
  assign unusedCtlBits = ^bus.cpuControlOut[31:3];

  assign txCmd  = (txToggle != txPrev);
  assign rxCmd  = (rxToggle != rxPrev);
  assign txPop  = !txEmpty && bus.txReady;
  assign rxPush = bus.rxValid && !rxFull;
  assign rxPop  = rxCmd && !rxEmpty;

  // A full TX FIFO only drops the word when the sink is not draining it
  assign newOverflow  = txCmd && txFull && !txPop;
  // Judged on pre-edge occupancy: a same-edge stream push cannot satisfy it
  assign newUnderflow = rxCmd && rxEmpty;

  port_stream_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2), .WIDTH(32)) txFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (txCmd),
    .pushData (bus.cpuDataOut),
    .pop      (txPop),
    .head     (txHead),
    .count    (txCount),
    .full     (txFull),
    .empty    (txEmpty)
  );

  port_stream_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2), .WIDTH(32)) rxFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (rxPush),
    .pushData (bus.rxData),
    .pop      (rxPop),
    .head     (rxHead),
    .count    (rxCount),
    .full     (rxFull),
    .empty    (rxEmpty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txPrev      <= 1'b0;
      rxPrev      <= 1'b0;
      txAck       <= 1'b0;
      rxAck       <= 1'b0;
      txOverflow  <= 1'b0;
      rxUnderflow <= 1'b0;
    end else begin
      if (txCmd) begin
        txPrev <= txToggle;
        txAck  <= txToggle;
      end
      if (rxCmd) begin
        rxPrev <= rxToggle;
        rxAck  <= rxToggle;
      end
      // A fresh error at the clearing edge still sets the flag
      txOverflow  <= (txOverflow  && !clearErrors) || newOverflow;
      rxUnderflow <= (rxUnderflow && !clearErrors) || newUnderflow;
    end
  end

  always_comb begin
    status                                   = '0;
    status[TX_ACK_BIT]                       = txAck;
    status[RX_ACK_BIT]                       = rxAck;
    status[TX_FULL_BIT]                      = txFull;
    status[TX_EMPTY_BIT]                     = txEmpty;
    status[RX_EMPTY_BIT]                     = rxEmpty;
    status[RX_FULL_BIT]                      = rxFull;
    status[TX_OVERFLOW_BIT]                  = txOverflow;
    status[RX_UNDERFLOW_BIT]                 = rxUnderflow;
    status[TX_COUNT_LSB +: COUNT_FIELD_W]    = COUNT_FIELD_W'(txCount);
    status[RX_COUNT_LSB +: COUNT_FIELD_W]    = COUNT_FIELD_W'(rxCount);
  end

  assign bus.cpuStatusIn = status;
  assign bus.cpuDataIn   = rxEmpty ? '0 : rxHead;
  assign bus.txData      = txHead;
  assign bus.txValid     = !txEmpty;
  assign bus.rxReady     = !rxFull;

endmodule

// File: tb/tb_port_stream_bridge.sv
// Bench for port_stream_bridge: directed steps followed by random traffic,
// compared against a queue-based model of the bridge's documented behaviour.
module tb_port_stream_bridge;
  import JZJCoreFTypes::*;

  localparam int DEPTH = 8;

  logic clock;
  logic reset;
  int   compared;
  int   mismatched;

  logic [31:0] mTxQ[$];
  logic [31:0] mRxQ[$];
  logic        mTxPrev, mRxPrev, mTxAck, mRxAck, mOvf, mUnd;

  port_stream_bridge_if bus();

  port_stream_bridge #(.FIFO_DEPTH_LOG2(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mTxQ.delete();
    mRxQ.delete();
    mTxPrev = 1'b0;
    mRxPrev = 1'b0;
    mTxAck  = 1'b0;
    mRxAck  = 1'b0;
    mOvf    = 1'b0;
    mUnd    = 1'b0;
  endtask

  function automatic logic [31:0] expStatus();
    logic [31:0] s;
    s      = '0;
    s[0]   = mTxAck;
    s[1]   = mRxAck;
    s[2]   = (mTxQ.size() == DEPTH);
    s[3]   = (mTxQ.size() == 0);
    s[4]   = (mRxQ.size() == 0);
    s[5]   = (mRxQ.size() == DEPTH);
    s[6]   = mOvf;
    s[7]   = mUnd;
    s[15:8]  = 8'(mTxQ.size());
    s[23:16] = 8'(mRxQ.size());
    return s;
  endfunction

  // Advance the model by one clock edge using the inputs presented now
  task automatic modelEdge();
    int txN, rxN;
    bit txPop, txCmd, rxCmd, rxPush;
    if (!reset) begin
      modelReset();
      return;
    end
    txN    = mTxQ.size();
    rxN    = mRxQ.size();
    txPop  = (txN > 0) && bus.txReady;
    txCmd  = (bus.cpuControlOut[0] != mTxPrev);
    rxCmd  = (bus.cpuControlOut[1] != mRxPrev);
    rxPush = bus.rxValid && (rxN < DEPTH);
    if (bus.cpuControlOut[2]) begin
      mOvf = 1'b0;
      mUnd = 1'b0;
    end
    if (txPop) void'(mTxQ.pop_front());
    if (txCmd) begin
      mTxPrev = bus.cpuControlOut[0];
      mTxAck  = bus.cpuControlOut[0];
      if (txN < DEPTH || txPop) mTxQ.push_back(bus.cpuDataOut);
      else mOvf = 1'b1;
    end
    if (rxCmd) begin
      mRxPrev = bus.cpuControlOut[1];
      mRxAck  = bus.cpuControlOut[1];
      if (rxN > 0) void'(mRxQ.pop_front());
      else mUnd = 1'b1;
    end
    if (rxPush) mRxQ.push_back(bus.rxData);
  endtask

  task automatic checkAll(input string where);
    chk({where, ".status"}, bus.cpuStatusIn, expStatus());
    chk({where, ".cpuDataIn"}, bus.cpuDataIn, (mRxQ.size() == 0) ? 32'h0 : mRxQ[0]);
    chk({where, ".txValid"}, 32'(bus.txValid), 32'(mTxQ.size() != 0));
    chk({where, ".rxReady"}, 32'(bus.rxReady), 32'(mRxQ.size() != DEPTH));
    if (mTxQ.size() != 0) chk({where, ".txData"}, bus.txData, mTxQ[0]);
  endtask

  task automatic cycle(input string where);
    modelEdge();
    @(posedge clock);
    #1;
    checkAll(where);
  endtask

  task automatic flipTx(input logic [31:0] data);
    bus.cpuDataOut       = data;
    bus.cpuControlOut[0] = ~bus.cpuControlOut[0];
  endtask

  task automatic flipRx();
    bus.cpuControlOut[1] = ~bus.cpuControlOut[1];
  endtask

  initial begin
    compared          = 0;
    mismatched        = 0;
    reset             = 1'b0;
    bus.cpuDataOut    = '0;
    bus.cpuControlOut = '0;
    bus.txReady       = 1'b0;
    bus.rxData        = '0;
    bus.rxValid       = 1'b0;
    modelReset();
    #1;
    checkAll("rst0");
    chk("rst0.statusConst", bus.cpuStatusIn, 32'h0000_0018);
    cycle("rst1");
    cycle("rst2");
    reset = 1'b1;
    cycle("release");

    // TX path
    flipTx(32'hDEAD_BEEF);
    cycle("tx1");
    chk("tx1.txData", bus.txData, 32'hDEAD_BEEF);
    chk("tx1.txValid", 32'(bus.txValid), 32'd1);
    chk("tx1.txAck", 32'(bus.cpuStatusIn[0]), 32'd1);
    chk("tx1.txCount", 32'(bus.cpuStatusIn[15:8]), 32'd1);
    bus.txReady = 1'b1;
    cycle("txPop");
    bus.txReady = 1'b0;
    chk("txPop.txEmpty", 32'(bus.cpuStatusIn[3]), 32'd1);

    // TX overflow, clear, and full-with-pop acceptance
    for (int i = 1; i <= 9; i++) begin
      flipTx(32'(i));
      cycle("txFill");
    end
    chk("ovf.txCount", 32'(bus.cpuStatusIn[15:8]), 32'd8);
    chk("ovf.txFull", 32'(bus.cpuStatusIn[2]), 32'd1);
    chk("ovf.flag", 32'(bus.cpuStatusIn[6]), 32'd1);
    chk("ovf.txData", bus.txData, 32'd1);
    bus.cpuControlOut[2] = 1'b1;
    cycle("clr");
    bus.cpuControlOut[2] = 1'b0;
    chk("clr.flag", 32'(bus.cpuStatusIn[6]), 32'd0);
    flipTx(32'h0000_000A);
    bus.txReady = 1'b1;
    cycle("fullPop");
    chk("fullPop.txCount", 32'(bus.cpuStatusIn[15:8]), 32'd8);
    chk("fullPop.flag", 32'(bus.cpuStatusIn[6]), 32'd0);
    chk("fullPop.txData", bus.txData, 32'd2);
    for (int i = 0; i < 8; i++) cycle("txDrain");
    bus.txReady = 1'b0;
    chk("txDrain.txEmpty", 32'(bus.cpuStatusIn[3]), 32'd1);

    // RX path
    bus.rxValid = 1'b1;
    bus.rxData  = 32'h11;
    cycle("rx11");
    bus.rxData  = 32'h22;
    cycle("rx22");
    bus.rxValid = 1'b0;
    chk("rx.cpuDataIn", bus.cpuDataIn, 32'h11);
    chk("rx.rxCount", 32'(bus.cpuStatusIn[23:16]), 32'd2);
    flipRx();
    cycle("rxPop1");
    chk("rxPop1.cpuDataIn", bus.cpuDataIn, 32'h22);
    chk("rxPop1.rxAck", 32'(bus.cpuStatusIn[1]), 32'd1);
    flipRx();
    cycle("rxPop2");
    chk("rxPop2.cpuDataIn", bus.cpuDataIn, 32'h0);
    chk("rxPop2.rxEmpty", 32'(bus.cpuStatusIn[4]), 32'd1);

    // RX underflow with a simultaneous incoming word, then backpressure
    flipRx();
    bus.rxValid = 1'b1;
    bus.rxData  = 32'h33;
    cycle("und");
    chk("und.flag", 32'(bus.cpuStatusIn[7]), 32'd1);
    chk("und.rxCount", 32'(bus.cpuStatusIn[23:16]), 32'd1);
    chk("und.cpuDataIn", bus.cpuDataIn, 32'h33);
    for (int i = 0; i < 7; i++) begin
      bus.rxData = 32'h100 + 32'(i);
      cycle("rxFill");
    end
    chk("rxFull.rxReady", 32'(bus.rxReady), 32'd0);
    chk("rxFull.rxCount", 32'(bus.cpuStatusIn[23:16]), 32'd8);
    bus.rxData = 32'h999;
    cycle("rxHold1");
    cycle("rxHold2");
    chk("rxHold.rxCount", 32'(bus.cpuStatusIn[23:16]), 32'd8);
    flipRx();
    cycle("rxFreeSlot");
    chk("rxFreeSlot.rxCount", 32'(bus.cpuStatusIn[23:16]), 32'd7);
    chk("rxFreeSlot.cpuDataIn", bus.cpuDataIn, 32'h100);
    cycle("rxNinth");
    chk("rxNinth.rxCount", 32'(bus.cpuStatusIn[23:16]), 32'd8);
    bus.rxValid = 1'b0;
    bus.cpuControlOut[2] = 1'b1;
    cycle("clr2");
    bus.cpuControlOut[2] = 1'b0;

    // Random traffic, sink-starved first half then source-starved second half
    for (int i = 0; i < 600; i++) begin
      bus.cpuDataOut = $urandom;
      bus.rxData     = $urandom;
      if ($urandom_range(0, 2) == 0) bus.cpuControlOut[0] = ~bus.cpuControlOut[0];
      if ($urandom_range(0, 2) == 0) bus.cpuControlOut[1] = ~bus.cpuControlOut[1];
      bus.cpuControlOut[2] = ($urandom_range(0, 15) == 0);
      if (i < 300) begin
        bus.txReady = ($urandom_range(0, 3) == 0);
        bus.rxValid = ($urandom_range(0, 3) != 0);
      end else begin
        bus.txReady = ($urandom_range(0, 3) != 0);
        bus.rxValid = ($urandom_range(0, 3) == 0);
      end
      cycle("rand");
    end

    // Reset mid-transfer with three words queued each way
    bus.cpuControlOut = '0;
    bus.txReady       = 1'b0;
    bus.rxValid       = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll("preRst");
    @(posedge clock);
    #1;
    reset = 1'b1;
    cycle("preRstRel");
    for (int i = 0; i < 3; i++) begin
      flipTx(32'hA000 + 32'(i));
      bus.rxValid = 1'b1;
      bus.rxData  = 32'hB000 + 32'(i);
      cycle("queue3");
    end
    bus.rxValid = 1'b1;
    bus.txReady = 1'b1;
    chk("queue3.txCount", 32'(bus.cpuStatusIn[15:8]), 32'd3);
    chk("queue3.rxCount", 32'(bus.cpuStatusIn[23:16]), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    chk("midRst.status", bus.cpuStatusIn, 32'h0000_0018);
    chk("midRst.txValid", 32'(bus.txValid), 32'd0);
    chk("midRst.rxReady", 32'(bus.rxReady), 32'd1);
    chk("midRst.cpuDataIn", bus.cpuDataIn, 32'h0);
    cycle("inRst1");
    cycle("inRst2");
    bus.cpuControlOut = '0;
    bus.txReady       = 1'b0;
    bus.rxValid       = 1'b0;
    reset = 1'b1;
    cycle("postRst");
    chk("postRst.status", bus.cpuStatusIn, 32'h0000_0018);
    chk("postRst.txValid", 32'(bus.txValid), 32'd0);
    chk("postRst.rxReady", 32'(bus.rxReady), 32'd1);
    chk("postRst.cpuDataIn", bus.cpuDataIn, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/port_stream_bridge.md
# port_stream_bridge

Memory-mapped stream bridge that sits on the far side of the CPU's memory-mapped port pair A/B (`portAOutput`/`portBOutput`, driven by the CPU, and `portAInput`/`portBInput`, read by the CPU). CPU stores become words pushed into a TX FIFO toward an external valid/ready stream. Words arriving on an external RX stream are buffered and exposed for CPU loads. Because the CPU can only write and read port registers, all transfers use toggle handshakes on a control word.

## Interface
- `FIFO_DEPTH_LOG2`, default 3: log2 of entries in each FIFO. Legal range 1..7.
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `cpuDataOut` in 32: from `portAOutput`; the TX word.
- `cpuControlOut` in 32: from `portBOutput`.
  - [0] txToggle
  - [1] rxToggle
  - [2] clearErrors (level-sensitive)
  - other bits ignored
- `cpuDataIn` out 32: to `portAInput`; RX FIFO head, or 0 when the RX FIFO is empty.
- `cpuStatusIn` out 32: to `portBInput`.
  - [0] txAck
  - [1] rxAck
  - [2] txFull
  - [3] txEmpty
  - [4] rxEmpty
  - [5] rxFull
  - [6] txOverflow (sticky)
  - [7] rxUnderflow (sticky)
  - [15:8] txCount
  - [23:16] rxCount
  - [31:24] = 0
- `txData` out 32: TX FIFO head.
- `txValid` out 1: equals !txEmpty.
- `txReady` in 1: pop the TX FIFO at a posedge where txValid && txReady.
- `rxData` in 32: incoming word.
- `rxValid` in 1: push the RX FIFO at a posedge where rxValid && rxReady.
- `rxReady` out 1: equals !rxFull.

## Operation
- **Registers.** Toggle detectors hold txPrev and rxPrev. A status register holds txAck, rxAck and the two stickies. There are two FIFOs. Words pass through unmodified, with no byte swapping.
- **TX command.** A TX command is any posedge where cpuControlOut[0] != txPrev.
  - At that edge: txPrev <= bit0 and txAck <= bit0.
  - If the TX FIFO is not full, or a TX pop occurs at the same edge, cpuDataOut is pushed.
  - Otherwise the word is dropped and txOverflow <= 1.
- **RX pop command.** An RX pop command is any posedge where cpuControlOut[1] != rxPrev.
  - At that edge: rxPrev <= bit1 and rxAck <= bit1.
  - If the RX FIFO is not empty, the head is popped.
  - Otherwise nothing is popped and rxUnderflow <= 1.
  - A word pushed from the external RX stream at the same edge does not satisfy an empty-FIFO pop.
- **Clearing stickies.**
  - clearErrors = 1 clears both stickies at every edge.
  - A new overflow or underflow at the same edge wins, leaving the flag at 1.
- **CPU sequences.**
  - Send: write the data to port A, then flip bit0 of port B, then poll until txAck equals the written bit.
  - Receive: check rxEmpty = 0, load port A, then flip bit1 and poll rxAck.
- **Counts.**
  - Counts are FIFO_DEPTH_LOG2+1 bits wide, zero-extended into the 8-bit status fields.
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG2.
  - Full means count == depth; empty means count == 0.
- **Reset.** While reset = 0:
  - pointers, counts, txPrev, rxPrev, txAck, rxAck and both stickies are 0;
  - txValid = 0, rxReady = 1, cpuDataIn = 0;
  - cpuStatusIn = 0x0000_0018 (txEmpty and rxEmpty set).
  - FIFO storage is not reset.
- **Reset mid-operation.** A reset during operation discards all buffered words. An asserted txReady or rxValid during reset has no effect.

## Timing
- All state updates on posedge clock. All outputs are derived from registers with no combinational path from any input.
- **TX latency.** A toggle sampled at edge N is visible at edge N+1:
  - the word appears on txData (if the FIFO was empty) with txValid = 1;
  - txAck and txCount update in the same cycle.
- **RX latency.**
  - A word accepted at edge N is visible on cpuDataIn after edge N, with rxEmpty = 0.
  - After a pop at edge N, cpuDataIn shows the next entry, or 0.
- **Simultaneous TX push and pop:**
  - when full, the push is accepted;
  - when empty, the pop is impossible because txValid = 0.
- **Simultaneous RX push and pop when non-empty:** both are performed and the count is unchanged.
- **Toggle rate.** At most one command per toggle change. A toggle held steady generates nothing. The CPU cannot produce toggles faster than one per store, so no toggle queuing is required.

## Structure
- A shared package (`JZJCoreFTypes`) gets localparams for:
  - control bit indices (TX_TOGGLE_BIT, RX_TOGGLE_BIT, CLEAR_ERRORS_BIT);
  - status bit and field positions (bits 0–7, TX_COUNT_LSB, RX_COUNT_LSB).
- One sub-module, `port_stream_fifo`:
  - parameterized show-ahead FIFO with push, pop, head, count, full and empty;
  - pop-before-push allowed when full;
  - instantiated twice (TX, RX).
- The top module holds the toggle detectors, status register and status/data muxing.

## Test plan
- **Reset values.** Assert reset mid-transfer with 3 words queued in each FIFO.
  - Expect cpuStatusIn = 0x0000_0018, txValid = 0, rxReady = 1 and cpuDataIn = 0 immediately (asynchronously).
  - Expect the same values to hold after release.
- **TX path.** Write cpuDataOut = 0xDEADBEEF and flip bit0 with txReady = 0.
  - Next cycle: txData = 0xDEADBEEF, txValid = 1, txAck = 1, txCount = 1.
  - Raise txReady: one word leaves, then txEmpty = 1.
- **TX overflow and clear.** With FIFO_DEPTH_LOG2 = 3 and txReady = 0, issue 9 toggles with data 1..9.
  - Expect txCount = 8, txFull = 1, txOverflow = 1, and txData = 1 after draining order 1..8.
  - clearErrors = 1 clears the flag.
  - A toggle on the full FIFO at the same edge as a txReady pop is accepted.
- **RX path.** Stream 0x11, 0x22 in with rxValid.
  - Expect cpuDataIn = 0x11 and rxCount = 2.
  - Flip bit1: cpuDataIn = 0x22, rxAck = 1.
  - Flip again: cpuDataIn = 0, rxEmpty = 1.
- **RX underflow and backpressure.**
  - Flip bit1 when empty while rxValid delivers 0x33 at the same edge: rxUnderflow = 1, rxCount = 1, cpuDataIn = 0x33.
  - Fill 8 words: rxReady = 0, and a ninth offered word is not accepted until one pop.
